alu_exec_stage: RTL and testbench

Registered execute stage that consumes the 3-bit `ALUControl` code from the ALU decoder together with two operands and produces `ALUResult` and `Zero` for downstream writeback and branch logic. Valid/ready handshakes on both sides let the core stall around it. ALU ops complete in one cycle. An optional iterative shifter extends the code space with multi-cycle shift operations.

---
 rtl/alu_exec_stage_if.sv | 24 ++
 rtl/alu_exec_stage.sv | 134 +++++++++++++
 tb/tb_alu_exec_stage.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_stage_if.sv
// Handshake bundle for alu_exec_stage: operand/opcode request side and result side.
// master drives operands and out_ready; slave is the execute stage itself.
interface alu_exec_stage_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Illegal;

    modport master (
        output in_valid, ALUControl, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, Illegal
    );

    modport slave (
        input  in_valid, ALUControl, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero, Illegal
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage (ADD/SUB/AND/OR/SLT); ALU_SHIFT_EN adds iterative SLL/SRL/SRA.
// Latency: 1 cycle; shifts by n>=1 take n+1 cycles, shamt=0 behaves as single-cycle.
// Backpressure: result held while out_valid && !out_ready; in_ready low during shifts and stalls.
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    alu_exec_stage_if.slave bus
);
    logic [WIDTH-1:0] res_q, res_nxt, alu_res;
    logic             zero_q, ill_q, vld_q;
    logic             ill_nxt, alu_ill, ld, in_rdy, accept;

    assign accept        = bus.in_valid && in_rdy;
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = vld_q;
    assign bus.ALUResult = res_q;
    assign bus.Zero      = zero_q;
    assign bus.Illegal   = ill_q;

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (bus.ALUControl)
            3'b000:  alu_res = bus.SrcA + bus.SrcB;
            3'b001:  alu_res = bus.SrcA - bus.SrcB;
            3'b010:  alu_res = bus.SrcA & bus.SrcB;
            3'b011:  alu_res = bus.SrcA | bus.SrcB;
            3'b101:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.SrcA) < $signed(bus.SrcB)};
`ifdef ALU_SHIFT_EN
            // Shift by zero: passes SrcA straight through as a single-cycle op.
            default: alu_res = bus.SrcA;
`else
            default: alu_ill = 1'b1;
`endif
        endcase
    end

`ifdef ALU_SHIFT_EN
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt, acc_sh;
    logic [SHW-1:0]   cnt, cnt_nxt, shamt;
    logic [1:0]       sh_op, sh_op_nxt;
    logic             is_shift;

    assign shamt    = bus.SrcB[SHW-1:0];
    assign is_shift = bus.ALUControl[2] && (bus.ALUControl[1:0] != 2'b01);
    assign in_rdy   = (state == IDLE) && (!vld_q || bus.out_ready);

    always_comb begin
        case (sh_op)
            2'b00:   acc_sh = {acc[WIDTH-2:0], 1'b0};
            2'b10:   acc_sh = {1'b0, acc[WIDTH-1:1]};
            default: acc_sh = {acc[WIDTH-1], acc[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        sh_op_nxt = sh_op;
        ld        = 1'b0;
        res_nxt   = alu_res;
        ill_nxt   = alu_ill;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_shift && (shamt != '0)) begin
                        state_nxt = SHIFT;
                        acc_nxt   = bus.SrcA;
                        cnt_nxt   = shamt;
                        sh_op_nxt = bus.ALUControl[1:0];
                    end else begin
                        ld = 1'b1;
                    end
                end
            end
            SHIFT: begin
                acc_nxt = acc_sh;
                cnt_nxt = cnt - 1'b1;
                if (cnt == SHW'(1)) begin
                    state_nxt = IDLE;
                    ld        = 1'b1;
                    res_nxt   = acc_sh;
                    ill_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            sh_op <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            sh_op <= sh_op_nxt;
        end
    end
`else
    assign in_rdy  = !vld_q || bus.out_ready;
    assign ld      = accept;
    assign res_nxt = alu_res;
    assign ill_nxt = alu_ill;
`endif

    // Entering SHIFT needs out_ready when a result is pending, so the else-branch drains it.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= 1'b0;
            res_q  <= '0;
            zero_q <= 1'b0;
            ill_q  <= 1'b0;
        end else if (ld) begin
            vld_q  <= 1'b1;
            res_q  <= res_nxt;
            zero_q <= (res_nxt == '0);
            ill_q  <= ill_nxt;
        end else if (bus.out_ready) begin
            vld_q  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed literal cases plus randomized traffic against a behavioural model.
module tb_alu_exec_stage;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    alu_exec_stage_if #(.WIDTH(W)) bus ();

    alu_exec_stage #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: whole-operation semantics; lat is number of cycles spent shifting.
    task automatic model_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] r, output logic il, output int lat);
        int sh;
        sh  = int'(b % W);
        r   = '0;
        il  = 1'b0;
        lat = 0;
        case (c)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd5: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            default: begin
`ifdef ALU_SHIFT_EN
                lat = sh;
                if (c == 3'd4)      r = a << sh;
                else if (c == 3'd6) r = a >> sh;
                else                r = $signed(a) >>> sh;
`else
                r  = '0;
                il = 1'b1;
`endif
            end
        endcase
    endtask

    logic           m_init = 1'b0;
    logic           m_vld, m_zero, m_ill;
    logic [W-1:0]   m_res, m_pres;
    int             m_wait;

    always @(negedge clk) begin
        logic [W-1:0] r;
        logic         il, rdy, acc;
        int           lt;
        rdy = (m_wait == 0) && (!m_vld || bus.out_ready);
        if (m_init) begin
            check("m_out_valid", W'(bus.out_valid), W'(m_vld));
            check("m_in_ready", W'(bus.in_ready), W'(rdy));
            if (m_vld) begin
                check("m_result", bus.ALUResult, m_res);
                check("m_zero", W'(bus.Zero), W'(m_zero));
                check("m_illegal", W'(bus.Illegal), W'(m_ill));
            end
        end
        if (reset) begin
            m_init = 1'b1;
            m_vld  = 1'b0;
            m_wait = 0;
        end else if (m_init) begin
            acc = bus.in_valid && rdy;
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_vld  = 1'b1;
                    m_res  = m_pres;
                    m_zero = (m_pres == '0);
                    m_ill  = 1'b0;
                end
            end else if (acc) begin
                model_op(bus.ALUControl, bus.SrcA, bus.SrcB, r, il, lt);
                if (lt > 0) begin
                    m_wait = lt;
                    m_pres = r;
                    m_vld  = 1'b0;
                end else begin
                    m_vld  = 1'b1;
                    m_res  = r;
                    m_zero = (r == '0);
                    m_ill  = il;
                end
            end else if (bus.out_ready) begin
                m_vld = 1'b0;
            end
        end
    end

    // Called just after a rising edge; leaves just after a rising edge with the result drained.
    task automatic run_op(input string nm, input logic [2:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er, input logic ez,
                          input logic ei, input int lat);
        int k;
        bus.in_valid   = 1'b1;
        bus.ALUControl = c;
        bus.SrcA       = a;
        bus.SrcB       = b;
        bus.out_ready  = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_accept: in_ready never rose within 100 cycles", nm);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        if (lat > 1) begin
            repeat (lat - 2) @(posedge clk);
            @(negedge clk);
            check({nm, "_early"}, W'(bus.out_valid), W'(0));
            @(posedge clk);
        end
        @(negedge clk);
        check({nm, "_vld"}, W'(bus.out_valid), W'(1));
        check({nm, "_res"}, bus.ALUResult, er);
        check({nm, "_zero"}, W'(bus.Zero), W'(ez));
        check({nm, "_ill"}, W'(bus.Illegal), W'(ei));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic took;
        int   seen;
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.ALUControl = 3'd0;
        bus.SrcA       = '0;
        bus.SrcB       = '0;
        bus.out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_in_ready", W'(bus.in_ready), W'(1));
        check("rst_result", bus.ALUResult, W'(0));
        check("rst_zero", W'(bus.Zero), W'(0));
        check("rst_illegal", W'(bus.Illegal), W'(0));
        @(posedge clk);
        #1;

        run_op("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1);
        run_op("sub_neg", 3'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
        run_op("slt_lt", 3'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
        run_op("slt_ge", 3'd5, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1);
        run_op("and", 3'd2, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0, 1);
        run_op("or", 3'd3, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0, 1'b0, 1);
`ifdef ALU_SHIFT_EN
        run_op("sra31", 3'd7, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 32);
        run_op("sll0", 3'd4, 32'd1, 32'd0, 32'd1, 1'b0, 1'b0, 1);
        run_op("srl4", 3'd6, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, 5);

        // Reset lands on the third SHIFT cycle of an SRL by 10.
        bus.in_valid   = 1'b1;
        bus.ALUControl = 3'd6;
        bus.SrcA       = 32'h8000_0000;
        bus.SrcB       = 32'd10;
        @(negedge clk);
        check("srl_rst_accept", W'(bus.in_ready), W'(1));
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("srl_rst_vld", W'(bus.out_valid), W'(0));
        check("srl_rst_rdy", W'(bus.in_ready), W'(1));
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("srl_rst_no_result", W'(seen), W'(0));
        @(posedge clk);
        #1;
`else
        run_op("srl_illegal", 3'd6, 32'h1234_5678, 32'd3, 32'h0, 1'b1, 1'b1, 1);
        run_op("add_after_ill", 3'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1);
`endif

        // Four back-to-back ADDs with the consumer always ready.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid   = 1'b1;
            bus.ALUControl = 3'd0;
            bus.SrcA       = W'(100 * (i + 1));
            bus.SrcB       = W'(i);
            @(negedge clk);
            check("b2b_in_ready", W'(bus.in_ready), W'(1));
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_last", bus.ALUResult, W'(403));
        @(posedge clk);
        #1;

        // Stall: consumer busy for 3 cycles while a second op waits upstream.
        bus.in_valid   = 1'b1;
        bus.ALUControl = 3'd0;
        bus.SrcA       = 32'd10;
        bus.SrcB       = 32'd20;
        bus.out_ready  = 1'b0;
        @(posedge clk);
        #1;
        bus.SrcA = 32'd1;
        bus.SrcB = 32'd2;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", W'(bus.in_ready), W'(0));
            check("stall_result", bus.ALUResult, W'(30));
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("stall_second", bus.ALUResult, W'(3));
        @(posedge clk);
        #1;

        // Randomized traffic; operands held until accepted.
        took = 1'b0;
        bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!bus.in_valid || took) begin
                bus.in_valid   = ($urandom_range(0, 3) != 0);
                bus.ALUControl = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 4))
                    0:       bus.SrcA = '0;
                    1:       bus.SrcA = '1;
                    2:       bus.SrcA = 32'h8000_0000;
                    default: bus.SrcA = $urandom;
                endcase
                case ($urandom_range(0, 3))
                    0:       bus.SrcB = bus.SrcA;
                    1:       bus.SrcB = W'($urandom_range(0, 40));
                    default: bus.SrcB = $urandom;
                endcase
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            reset         = ($urandom_range(0, 499) == 0);
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
        end
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
